// File: rtl/core_mc_pkg.sv
// core_mc_pkg: shared FSM states, operand-select codes, opcodes and datapath helpers for core_mc
package core_mc_pkg;
  typedef enum logic [2:0] {FETCH, FETCH_WAIT, EXECUTE, MEMORY, MEM_WAIT, WRITE_BACK, TRAP} state_t;
  typedef enum logic [1:0] {ALU_A_PC, ALU_A_ZERO, ALU_A_RS1} alu_a_t;
  typedef enum logic [1:0] {ALU_B_4, ALU_B_IMM, ALU_B_RS2} alu_b_t;
  localparam logic [2:0] BRANCH_EQ = 3'b000, BRANCH_NE = 3'b001, BRANCH_LT = 3'b100;
  localparam logic [2:0] BRANCH_GE = 3'b101, BRANCH_LTU = 3'b110, BRANCH_GEU = 3'b111;
  localparam logic [2:0] MODE_FETCH = 3'b111;
  localparam logic [31:0] MRET = 32'h3020_0073;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

  function automatic logic [31:0] alu(logic [2:0] f3, logic alt, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'b000: return alt ? a - b : a + b;
      3'b001: return a << b[4:0];
      3'b010: return {31'b0, $signed(a) < $signed(b)};
      3'b011: return {31'b0, a < b};
      3'b100: return a ^ b;
      3'b101: return alt ? $signed(a) >>> b[4:0] : a >> b[4:0];
      3'b110: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] load_sext(logic [2:0] f3, logic [1:0] off, logic [31:0] d);
    logic [31:0] s;
    s = d >> {off, 3'b000};
    return f3 == 3'b000 ? {{24{s[7]}}, s[7:0]} :
           f3 == 3'b001 ? {{16{s[15]}}, s[15:0]} :
           f3 == 3'b100 ? {24'b0, s[7:0]} :
           f3 == 3'b101 ? {16'b0, s[15:0]} : s;
  endfunction

  function automatic logic [31:0] save_sext(logic [2:0] f3, logic [1:0] off, logic [31:0] d);
    logic [31:0] m;
    m = f3[1:0] == 2'b00 ? {24'b0, d[7:0]} : f3[1:0] == 2'b01 ? {16'b0, d[15:0]} : d;
    return m << {off, 3'b000};
  endfunction
endpackage

// File: rtl/core_mc_mem_if_timer.sv
// mem_if_timer: per-access wait counter; flags the cycle in which the wait budget runs out
module mem_if_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic busy_i,
  output logic timeout_o
);
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? 16'd0 : busy_i ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= 16'd0;
    else cnt_q <= cnt_d;
  assign timeout_o = busy_i && cnt_q == 16'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/core_mc.sv
// core_mc: multi-cycle RV32I core with a handshaked memory port, interrupt traps and bus timeouts
module core_mc import core_mc_pkg::*; #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h8000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h8000_0100,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            intr,
  output logic            intr_ack,
  output logic            mem_req,
  output logic            mem_wen,
  output logic [2:0]      mem_mode,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_dat_o,
  input  logic [XLEN-1:0] mem_dat_i,
  input  logic            mem_ready,
  output logic            bus_err,
  output logic [XLEN-1:0] pc_debug
);
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, mepc_q, mepc_d, inst_q, inst_d, alu_q, alu_d, ld_q, ld_d;
  logic [XLEN-1:0] addr_q, addr_d, dat_q, dat_d;
  logic mie_q, mie_d, taken_q, taken_d, cause_q, cause_d, req_q, req_d, wen_q, wen_d;
  logic [2:0] mode_q, mode_d;
  logic [XLEN-1:0] rf_q [32];
  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [XLEN-1:0] rs1_v, rs2_v, imm, op_a, op_b, alu_res, pc_next;
  alu_a_t sel_a;
  alu_b_t sel_b;
  logic is_arith, wr_en, mem_op, cond, timeout;
  assign opc = inst_q[6:0];
  assign rd = inst_q[11:7];
  assign f3 = inst_q[14:12];
  assign rs1 = inst_q[19:15];
  assign rs2 = inst_q[24:20];
  assign rs1_v = rs1 == 5'd0 ? '0 : rf_q[rs1];
  assign rs2_v = rs2 == 5'd0 ? '0 : rf_q[rs2];
  always_comb begin
    imm = opc == OP_STORE ? {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]} :
          opc == OP_BRANCH ? {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0} :
          opc == OP_JAL ? {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0} :
          (opc == OP_LUI || opc == OP_AUIPC) ? {inst_q[31:12], 12'b0} : {{20{inst_q[31]}}, inst_q[31:20]};
    sel_a = (opc == OP_AUIPC || opc == OP_JAL || opc == OP_JALR) ? ALU_A_PC : opc == OP_LUI ? ALU_A_ZERO : ALU_A_RS1;
    sel_b = (opc == OP_JAL || opc == OP_JALR) ? ALU_B_4 : (opc == OP_REG || opc == OP_BRANCH) ? ALU_B_RS2 : ALU_B_IMM;
    op_a = sel_a == ALU_A_PC ? pc_q : sel_a == ALU_A_ZERO ? '0 : rs1_v;
    op_b = sel_b == ALU_B_4 ? XLEN'(4) : sel_b == ALU_B_RS2 ? rs2_v : imm;
    is_arith = opc == OP_IMM || opc == OP_REG;
    // bit 30 selects SUB only for register ops, SRA/SRAI for both forms
    alu_res = alu(is_arith ? f3 : 3'b000, is_arith && inst_q[30] && (opc == OP_REG || f3 == 3'b101), op_a, op_b);
    wr_en = rd != 5'd0 && (is_arith || opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL || opc == OP_JALR || opc == OP_LOAD);
    mem_op = opc == OP_LOAD || opc == OP_STORE;
    cond = f3 == BRANCH_EQ ? rs1_v == rs2_v : f3 == BRANCH_NE ? rs1_v != rs2_v :
           f3 == BRANCH_LT ? $signed(rs1_v) < $signed(rs2_v) : f3 == BRANCH_GE ? $signed(rs1_v) >= $signed(rs2_v) :
           f3 == BRANCH_LTU ? rs1_v < rs2_v : f3 == BRANCH_GEU ? rs1_v >= rs2_v : 1'b0;
    pc_next = inst_q == MRET ? mepc_q : opc == OP_JALR ? (rs1_v + imm) & ~XLEN'(1) : taken_q ? pc_q + imm : pc_q + XLEN'(4);
  end
  mem_if_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk(clk), .rst(rst), .clr_i(state_q == FETCH || state_q == MEMORY),
    .busy_i(req_q && !mem_ready), .timeout_o(timeout)
  );
  always_comb begin
    state_d = state_q; pc_d = pc_q; mepc_d = mepc_q; mie_d = mie_q; inst_d = inst_q;
    alu_d = alu_q; ld_d = ld_q; taken_d = taken_q; cause_d = cause_q;
    req_d = req_q; wen_d = wen_q; mode_d = mode_q; addr_d = addr_q; dat_d = dat_q;
    case (state_q)
      FETCH: begin
        req_d = 1'b1; wen_d = 1'b0; mode_d = MODE_FETCH; addr_d = pc_q; state_d = FETCH_WAIT;
      end
      FETCH_WAIT:
        if (mem_ready) begin
          inst_d = mem_dat_i; req_d = 1'b0; state_d = EXECUTE;
        end else if (timeout) begin
          req_d = 1'b0; cause_d = 1'b1; state_d = TRAP;
        end
      EXECUTE: begin
        alu_d = alu_res; state_d = MEMORY;
      end
      MEMORY: begin
        taken_d = opc == OP_JAL || opc == OP_JALR || (opc == OP_BRANCH && cond);
        req_d = mem_op; wen_d = opc == OP_STORE; mode_d = f3; addr_d = alu_q;
        dat_d = opc == OP_STORE ? save_sext(f3, alu_q[1:0], rs2_v) : '0;
        state_d = mem_op ? MEM_WAIT : WRITE_BACK;
      end
      MEM_WAIT:
        if (mem_ready) begin
          ld_d = load_sext(mode_q, addr_q[1:0], mem_dat_i); req_d = 1'b0; state_d = WRITE_BACK;
        end else if (timeout) begin
          req_d = 1'b0; cause_d = 1'b1; state_d = TRAP;
        end
      WRITE_BACK: begin
        pc_d = pc_next;
        mie_d = inst_q == MRET ? 1'b1 : mie_q;
        cause_d = 1'b0;
        state_d = intr && mie_q ? TRAP : FETCH;
      end
      TRAP: begin
        mepc_d = pc_q; mie_d = 1'b0; pc_d = TRAP_VEC; state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= FETCH; pc_q <= RESET_VEC; mepc_q <= '0; mie_q <= 1'b1; inst_q <= '0;
      alu_q <= '0; ld_q <= '0; taken_q <= 1'b0; cause_q <= 1'b0;
      req_q <= 1'b0; wen_q <= 1'b0; mode_q <= 3'b000; addr_q <= '0; dat_q <= '0;
    end else begin
      state_q <= state_d; pc_q <= pc_d; mepc_q <= mepc_d; mie_q <= mie_d; inst_q <= inst_d;
      alu_q <= alu_d; ld_q <= ld_d; taken_q <= taken_d; cause_q <= cause_d;
      req_q <= req_d; wen_q <= wen_d; mode_q <= mode_d; addr_q <= addr_d; dat_q <= dat_d;
    end
  always_ff @(posedge clk)
    if (state_q == WRITE_BACK && wr_en) rf_q[rd] <= opc == OP_LOAD ? ld_q : alu_q;
  assign mem_req = req_q;
  assign mem_wen = wen_q;
  assign mem_mode = mode_q;
  assign mem_addr = addr_q;
  assign mem_dat_o = dat_q;
  assign pc_debug = pc_q;
  assign bus_err = state_q == TRAP && cause_q;
  assign intr_ack = state_q == TRAP && !cause_q;
endmodule

// File: tb/tb_core_mc.sv
// tb_core_mc: directed program run against core_mc with a delay-programmable memory responder
module tb_core_mc;
  logic clk = 1'b0;
  logic rst, intr, intr_ack, mem_req, mem_wen, bus_err;
  logic mem_ready = 1'b0;
  logic [2:0] mem_mode;
  logic [31:0] mem_addr, mem_dat_o, pc_debug;
  logic [31:0] mem_dat_i = 32'h0;
  logic [31:0] mem [256];
  logic req_d = 1'b0;
  int delay = -1;
  int wcnt = 0;
  int total = 0;
  int bad = 0;

  core_mc dut (
    .clk(clk), .rst(rst), .intr(intr), .intr_ack(intr_ack), .mem_req(mem_req),
    .mem_wen(mem_wen), .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_dat_o(mem_dat_o),
    .mem_dat_i(mem_dat_i), .mem_ready(mem_ready), .bus_err(bus_err), .pc_debug(pc_debug)
  );

  always #5 clk = ~clk;
  always @(posedge clk) req_d <= mem_req;

  // ready arrives in the (delay+1)-th cycle of a request; delay<0 never answers
  always @(negedge clk) begin
    mem_ready = mem_req && wcnt == delay;
    mem_dat_i = mem_ready ? mem[{mem_addr[31], mem_addr[8:2]}] : 32'h0;
    wcnt = mem_req && !mem_ready ? wcnt + 1 : 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_req(output logic [31:0] a);
    int n;
    n = 0;
    a = 32'hDEAD_DEAD;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_req && !req_d) && n < 600);
    if (mem_req && !req_d) a = mem_addr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int n;
    logic ok;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[128] = 32'h00500093; // ADDI x1,x0,5
    mem[129] = 32'hFF908113; // ADDI x2,x1,-7
    mem[130] = 32'h002001A3; // SB x2,3(x0)
    mem[131] = 32'h00202223; // SW x2,4(x0)
    mem[132] = 32'h00200213; // ADDI x4,x0,2
    mem[133] = 32'h00108863; // BEQ x1,x1,+16
    mem[134] = 32'h00100293; // ADDI x5,x0,1 (skipped)
    mem[137] = 32'h00109463; // BNE x1,x1,+8
    mem[138] = 32'h800003B7; // LUI x7,0x80000
    mem[139] = 32'h06138367; // JALR x6,0x61(x7)
    mem[152] = 32'h00602423; // SW x6,8(x0)
    mem[153] = 32'h00300413; // ADDI x8,x0,3
    mem[192] = 32'h30200073; // MRET at trap vector
    rst = 1'b1;
    intr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_mode", mem_mode, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_dat", mem_dat_o, 0);
    chk("rst_ack", intr_ack, 0);
    chk("rst_berr", bus_err, 0);
    chk("rst_pc", pc_debug, 32'h8000_0000);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_req_fw", mem_req, 1);
    #2 rst = 1'b1;
    #1 chk("t1_async_drop", mem_req, 0);
    delay = 0;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("t1_req", mem_req, 1);
    chk("t1_addr", mem_addr, 32'h8000_0000);
    chk("t1_mode", mem_mode, 3'b111);
    repeat (8) @(negedge clk);
    chk("t2_pc9", pc_debug, 32'h8000_0004);
    @(negedge clk);
    chk("t2_pc10", pc_debug, 32'h8000_0008);
    delay = 4;
    next_req(a);
    chk("t3_fetch", a, 32'h8000_0008);
    next_req(a);
    chk("t3_sb_addr", a, 32'h0000_0003);
    chk("t3_sb_wen", mem_wen, 1);
    chk("t3_sb_mode", mem_mode, 3'b000);
    chk("t3_sb_dat", mem_dat_o, 32'hFE00_0000);
    n = 0;
    ok = 1'b1;
    while (mem_req && n < 20) begin
      if ({mem_addr, mem_dat_o, mem_mode, mem_wen} !== {32'h3, 32'hFE00_0000, 3'b000, 1'b1}) ok = 1'b0;
      n++;
      @(negedge clk);
    end
    chk("t3_hold_cycles", n, 5);
    chk("t3_stable", ok, 1);
    delay = 0;
    next_req(a);
    chk("t3_fetch_sw", a, 32'h8000_000C);
    next_req(a);
    chk("t3_sw_addr", a, 32'h0000_0004);
    chk("t3_sw_mode", mem_mode, 3'b010);
    chk("t2_x2", mem_dat_o, 32'hFFFF_FFFE);
    next_req(a);
    chk("t5_fetch", a, 32'h8000_0010);
    intr = 1'b1;
    n = 0;
    while (!intr_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_ack", intr_ack, 1);
    chk("t5_no_berr", bus_err, 0);
    intr = 1'b0;
    @(negedge clk);
    chk("t5_ack_pulse", intr_ack, 0);
    next_req(a);
    chk("t5_trap_vec", a, 32'h8000_0100);
    next_req(a);
    chk("t5_mret_ret", a, 32'h8000_0014);
    next_req(a);
    chk("t6_beq_taken", a, 32'h8000_0024);
    next_req(a);
    chk("t6_bne_not", a, 32'h8000_0028);
    next_req(a);
    chk("t6_lui_next", a, 32'h8000_002C);
    next_req(a);
    chk("t6_jalr_tgt", a, 32'h8000_0060);
    next_req(a);
    chk("t6_sw_addr", a, 32'h0000_0008);
    chk("t6_link", mem_dat_o, 32'h8000_0030);
    @(posedge clk);
    delay = -1;
    next_req(a);
    chk("t4_fetch", a, 32'h8000_0064);
    n = 0;
    while (!bus_err && n < 400) begin
      if (mem_req) n++;
      @(negedge clk);
    end
    chk("t4_wait_cycles", n, 255);
    chk("t4_berr", bus_err, 1);
    chk("t4_req_drop", mem_req, 0);
    chk("t4_no_ack", intr_ack, 0);
    delay = 0;
    @(negedge clk);
    chk("t4_berr_pulse", bus_err, 0);
    next_req(a);
    chk("t4_trap_vec", a, 32'h8000_0100);
    next_req(a);
    chk("t4_mepc", a, 32'h8000_0064);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
